// File: rtl/riscv_hazard_ctrl.sv
// riscv_hazard_ctrl: 5-stage RV32I hazard unit. It handles forwarding, load-use stalls, redirect flushes and variable-latency memory waits.
// Optional saturating stall/flush counters are built when RISCV_HAZARD_PERF_CNT_EN is defined.
module riscv_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [REG_ADDR_W-1:0] i_hazard_rs1_addr_d,
    input  logic [REG_ADDR_W-1:0] i_hazard_rs2_addr_d,
    input  logic [REG_ADDR_W-1:0] i_hazard_rs1_addr_e,
    input  logic [REG_ADDR_W-1:0] i_hazard_rs2_addr_e,
    input  logic [REG_ADDR_W-1:0] i_hazard_rd_addr_e,
    input  logic                  i_hazard_load_e,
    input  logic [1:0]            i_hazard_src_pc,
    input  logic [REG_ADDR_W-1:0] i_hazard_rd_addr_m,
    input  logic                  i_hazard_reg_wr_en_m,
    input  logic [REG_ADDR_W-1:0] i_hazard_rd_addr_w,
    input  logic                  i_hazard_reg_wr_en_w,
    input  logic                  i_hazard_mem_req_m,
    input  logic                  i_hazard_mem_ready,
    output logic [1:0]            o_hazard_forward_ae,
    output logic [1:0]            o_hazard_forward_be,
    output logic                  o_hazard_stall_f,
    output logic                  o_hazard_stall_d,
    output logic                  o_hazard_stall_e,
    output logic                  o_hazard_stall_m,
    output logic                  o_hazard_flush_d,
    output logic                  o_hazard_flush_e,
    output logic                  o_hazard_flush_w,
    output logic                  o_hazard_mem_wait,
    output logic                  o_hazard_timeout,
    output logic [CNT_W-1:0]      o_hazard_perf_stall_cnt,
    output logic [CNT_W-1:0]      o_hazard_perf_flush_cnt
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);
    localparam logic [7:0] WAIT_TO  = 8'(MAX_WAIT - 1);
    state_t     state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;
    logic       lwstall, redirect, memwait;

    assign lwstall  = i_hazard_load_e && (i_hazard_rd_addr_e != '0) &&
                      (i_hazard_rs1_addr_d == i_hazard_rd_addr_e || i_hazard_rs2_addr_d == i_hazard_rd_addr_e);
    assign redirect = i_hazard_src_pc != 2'b00;
    assign memwait  = i_hazard_mem_req_m && !i_hazard_mem_ready;

    always_comb begin
        o_hazard_forward_ae = (i_hazard_rs1_addr_e != '0 && i_hazard_rs1_addr_e == i_hazard_rd_addr_m && i_hazard_reg_wr_en_m) ? 2'b10 :
                              (i_hazard_rs1_addr_e != '0 && i_hazard_rs1_addr_e == i_hazard_rd_addr_w && i_hazard_reg_wr_en_w) ? 2'b01 : 2'b00;
        o_hazard_forward_be = (i_hazard_rs2_addr_e != '0 && i_hazard_rs2_addr_e == i_hazard_rd_addr_m && i_hazard_reg_wr_en_m) ? 2'b10 :
                              (i_hazard_rs2_addr_e != '0 && i_hazard_rs2_addr_e == i_hazard_rd_addr_w && i_hazard_reg_wr_en_w) ? 2'b01 : 2'b00;
        // A memory wait freezes everything and masks load-use/redirect until the access completes.
        o_hazard_stall_f = memwait || lwstall;
        o_hazard_stall_d = memwait || lwstall;
        o_hazard_stall_e = memwait;
        o_hazard_stall_m = memwait;
        o_hazard_flush_d = !memwait && redirect;
        o_hazard_flush_e = !memwait && (lwstall || redirect);
        o_hazard_flush_w = memwait;
    end

    always_comb begin
        state_next    = memwait ? MEM_WAIT : RUN;
        wait_cnt_next = !memwait ? 8'd0 :
                        (state == RUN) ? 8'd1 :
                        (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 8'd1;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state            <= RUN;
            wait_cnt         <= '0;
            o_hazard_timeout <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (memwait && wait_cnt == WAIT_TO)
                o_hazard_timeout <= 1'b1;
        end
    end

    assign o_hazard_mem_wait = state == MEM_WAIT;

`ifdef RISCV_HAZARD_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_hazard_perf_stall_cnt <= '0;
            o_hazard_perf_flush_cnt <= '0;
        end else begin
            if (o_hazard_stall_f && !(&o_hazard_perf_stall_cnt))
                o_hazard_perf_stall_cnt <= o_hazard_perf_stall_cnt + 1'b1;
            if ((o_hazard_flush_d || o_hazard_flush_e) && !(&o_hazard_perf_flush_cnt))
                o_hazard_perf_flush_cnt <= o_hazard_perf_flush_cnt + 1'b1;
        end
    end
`else
    assign o_hazard_perf_stall_cnt = '0;
    assign o_hazard_perf_flush_cnt = '0;
`endif
endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// tb_riscv_hazard_ctrl: directed vector table for the combinational paths plus hand sequences for memory wait, timeout and reset.
module tb_riscv_hazard_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       load_e, wen_m, wen_w, req, ready;
    logic [1:0] src_pc;
    logic [1:0] fae, fbe;
    logic       sf, sd, se, sm, fd, fe, fw, mem_wait, timeout;
    logic [15:0] stall_cnt, flush_cnt;
    int checks = 0, errors = 0;

    riscv_hazard_ctrl #(.REG_ADDR_W(5), .MAX_WAIT(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rstn(rst_n),
        .i_hazard_rs1_addr_d(rs1_d), .i_hazard_rs2_addr_d(rs2_d),
        .i_hazard_rs1_addr_e(rs1_e), .i_hazard_rs2_addr_e(rs2_e), .i_hazard_rd_addr_e(rd_e),
        .i_hazard_load_e(load_e), .i_hazard_src_pc(src_pc),
        .i_hazard_rd_addr_m(rd_m), .i_hazard_reg_wr_en_m(wen_m),
        .i_hazard_rd_addr_w(rd_w), .i_hazard_reg_wr_en_w(wen_w),
        .i_hazard_mem_req_m(req), .i_hazard_mem_ready(ready),
        .o_hazard_forward_ae(fae), .o_hazard_forward_be(fbe),
        .o_hazard_stall_f(sf), .o_hazard_stall_d(sd), .o_hazard_stall_e(se), .o_hazard_stall_m(sm),
        .o_hazard_flush_d(fd), .o_hazard_flush_e(fe), .o_hazard_flush_w(fw),
        .o_hazard_mem_wait(mem_wait), .o_hazard_timeout(timeout),
        .o_hazard_perf_stall_cnt(stall_cnt), .o_hazard_perf_flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic       load_e, wen_m, wen_w, req, ready;
        logic [1:0] src_pc;
        logic [10:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] outs();
        return {fae, fbe, sf, sd, se, sm, fd, fe, fw};
    endfunction

    task automatic idle();
        {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
        {load_e, wen_m, wen_w, req, ready} = '0;
        src_pc = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_mem_wait", 32'(mem_wait), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_flush_cnt", 32'(flush_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t v[10];
    int exp_flush, exp_stall;

    initial begin
        // exp = {fae, fbe, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
        v[0] = '{"fwd_m_w",     0,0,5,7,0,5,7, 0,1,1,0,0, 2'b00, 11'b10_01_0000000};
        v[1] = '{"fwd_m_prio",  0,0,5,0,0,5,5, 0,1,1,0,0, 2'b00, 11'b10_00_0000000};
        v[2] = '{"fwd_x0",      0,0,0,0,0,0,0, 0,1,1,0,0, 2'b00, 11'b00_00_0000000};
        v[3] = '{"fwd_w_only",  0,0,5,5,0,5,5, 0,0,1,0,0, 2'b00, 11'b01_01_0000000};
        v[4] = '{"lwstall_rs2", 0,3,0,0,3,0,0, 1,0,0,0,0, 2'b00, 11'b00_00_1100010};
        v[5] = '{"lw_rd0",      0,0,0,0,0,0,0, 1,0,0,0,0, 2'b00, 11'b00_00_0000000};
        v[6] = '{"no_load",     0,3,0,0,3,0,0, 0,0,0,0,0, 2'b00, 11'b00_00_0000000};
        v[7] = '{"lwstall_rs1", 4,0,0,0,4,0,0, 1,0,0,0,0, 2'b00, 11'b00_00_1100010};
        v[8] = '{"redirect",    0,0,0,0,0,0,0, 0,0,0,0,0, 2'b11, 11'b00_00_0000110};
        v[9] = '{"mem_1cycle",  0,0,0,0,0,0,0, 0,0,0,1,1, 2'b00, 11'b00_00_0000000};
`ifdef RISCV_HAZARD_PERF_CNT_EN
        exp_flush = 1; exp_stall = 3;
`else
        exp_flush = 0; exp_stall = 0;
`endif
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rs1_d = v[i].rs1_d; rs2_d = v[i].rs2_d; rs1_e = v[i].rs1_e; rs2_e = v[i].rs2_e;
            rd_e = v[i].rd_e; rd_m = v[i].rd_m; rd_w = v[i].rd_w; load_e = v[i].load_e;
            wen_m = v[i].wen_m; wen_w = v[i].wen_w; req = v[i].req; ready = v[i].ready;
            src_pc = v[i].src_pc;
            #1 chk(v[i].name, 32'(outs()), 32'(v[i].exp));
        end
        @(posedge clk); #1 chk("single_cycle_no_wait", 32'(mem_wait), 0);

        // one-cycle redirect
        do_reset();
        @(negedge clk); src_pc = 2'b01;
        #1 chk("redir_on", 32'({fd, fe}), 32'b11);
        @(negedge clk); src_pc = 2'b00;
        #1 chk("redir_off", 32'({fd, fe}), 32'b00);
        chk("perf_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

        // three-cycle memory wait
        do_reset();
        @(negedge clk); req = 1'b1; ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("wait_stalls", 32'({sf, sd, se, sm, fw, fd, fe}), 32'b1111100);
            chk("wait_mem_wait", 32'(mem_wait), 32'(i > 0));
        end
        @(negedge clk); ready = 1'b1;
        #1 chk("wait_release", 32'({sf, sd, se, sm, fw}), 0);
        chk("wait_mem_wait_c4", 32'(mem_wait), 1);
        @(negedge clk); req = 1'b0;
        #1 chk("wait_back_run", 32'(mem_wait), 0);
        chk("wait_no_timeout", 32'(timeout), 0);
        chk("perf_stall_cnt", 32'(stall_cnt), 32'(exp_stall));

        // timeout with MAX_WAIT = 4 over six not-ready cycles
        do_reset();
        @(negedge clk); req = 1'b1; ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1 chk("timeout_cycle", 32'(timeout), 32'(i >= 4));
        end
        @(negedge clk); ready = 1'b1;
        #1 chk("timeout_sticky_ready", 32'(timeout), 1);
        @(negedge clk); req = 1'b0;
        @(negedge clk); #1 chk("timeout_sticky_idle", 32'(timeout), 1);

        // asynchronous reset in the middle of a wait
        req = 1'b1; ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        chk("pre_rst_mem_wait", 32'(mem_wait), 1);
        rst_n = 1'b0;
        #1 chk("async_rst_mem_wait", 32'(mem_wait), 0);
        chk("async_rst_timeout", 32'(timeout), 0);
        chk("rst_comb_follow", 32'({sf, se, fw}), 32'b111);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) @(posedge clk);
        #1 chk("reentry_mem_wait", 32'(mem_wait), 1);
        chk("reentry_no_timeout_yet", 32'(timeout), 0);
        @(posedge clk); #1 chk("reentry_timeout", 32'(timeout), 1);

        // memory wait masks redirect and load-use
        do_reset();
        @(negedge clk);
        req = 1'b1; ready = 1'b0; src_pc = 2'b10; load_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3;
        #1 chk("prio_wait", 32'({sf, sd, se, sm, fd, fe, fw}), 32'b1111001);
        @(negedge clk); ready = 1'b1;
        #1 chk("prio_release", 32'({sf, sd, se, sm, fd, fe, fw}), 32'b1100110);
        idle();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
